// File: rtl/drip_zone_scheduler.sv
// Round-robin drip valve scheduler: one timed burst at a time across ZONES zones under a shared permit.
// Optional post-burst soak period enabled by defining DRIP_SOAK_EN.
module drip_zone_scheduler #(
  parameter int ZONES       = 4,
  parameter int CNT_W       = 16,
  parameter int DRIP_CYCLES = 1000,
  parameter int SOAK_CYCLES = 500
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [ZONES-1:0]         irrigation_state_i,
  input  logic                     medium_level_indicator_i,
  input  logic                     low_level_indicator_i,
  input  logic                     temperature_i,
  input  logic                     air_humidity_i,
  output logic [ZONES-1:0]         drip_state_o,
  output logic [$clog2(ZONES)-1:0] active_zone_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     abort_o
);

  localparam int ZW = $clog2(ZONES);
  localparam logic [CNT_W-1:0] DRIP_LAST = CNT_W'(DRIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOAK_LAST = CNT_W'(SOAK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRIP = 2'd1,
    S_SOAK = 2'd2
  } state_t;

  state_t           r_state;
  logic [ZONES-1:0] r_drip;
  logic [ZW-1:0]    r_zone;
  logic [ZW-1:0]    r_ptr;
  logic             r_busy;
  logic             r_done;
  logic             r_abort;
  logic [CNT_W-1:0] r_cnt;

  logic               w_permit;
  logic [2*ZONES-1:0] w_dbl;
  logic [ZW:0]        w_shift;
  logic [ZONES-1:0]   w_rot;
  logic [ZW-1:0]      w_off;
  logic [ZW:0]        w_sum;
  logic [ZW-1:0]      w_grant;
  logic [ZONES-1:0]   w_grant_onehot;

  // Lowest set bit index; scanning downward lets the lowest index overwrite.
  function automatic logic [ZW-1:0] f_first_set(input logic [ZONES-1:0] v);
    f_first_set = '0;
    for (int k = ZONES - 1; k >= 0; k--) begin
      if (v[k]) f_first_set = ZW'(k);
    end
  endfunction

  assign w_permit = air_humidity_i & (~medium_level_indicator_i | temperature_i) & low_level_indicator_i;

  // Rotate requests so bit 0 is the zone just after the pointer, then undo the rotation.
  assign w_dbl          = {irrigation_state_i, irrigation_state_i};
  assign w_shift        = {1'b0, r_ptr} + (ZW+1)'(1);
  assign w_rot          = ZONES'(w_dbl >> w_shift);
  assign w_off          = f_first_set(w_rot);
  assign w_sum          = w_shift + {1'b0, w_off};
  assign w_grant        = (w_sum >= (ZW+1)'(ZONES)) ? ZW'(w_sum - (ZW+1)'(ZONES)) : ZW'(w_sum);
  assign w_grant_onehot = {{(ZONES-1){1'b0}}, 1'b1} << w_grant;

  // Burst state machine with registered valve and status outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_drip  <= '0;
      r_zone  <= '0;
      r_ptr   <= ZW'(ZONES - 1);
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_permit && (|irrigation_state_i)) begin
            r_state <= S_DRIP;
            r_drip  <= w_grant_onehot;
            r_zone  <= w_grant;
            r_ptr   <= w_grant;
            r_busy  <= 1'b1;
          end else begin
            r_drip <= '0;
            r_busy <= 1'b0;
          end
        end
        S_DRIP: begin
          if (!w_permit || !irrigation_state_i[r_zone]) begin
            r_state <= S_IDLE;
            r_drip  <= '0;
            r_busy  <= 1'b0;
            r_abort <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == DRIP_LAST) begin
            r_drip <= '0;
            r_done <= 1'b1;
            r_cnt  <= '0;
`ifdef DRIP_SOAK_EN
            r_state <= S_SOAK;
            r_busy  <= 1'b1;
`else
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        // Only reachable with soak enabled; otherwise it just falls back to IDLE.
        S_SOAK: begin
          r_drip <= '0;
          if (r_cnt == SOAK_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_drip  <= '0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign drip_state_o  = r_drip;
  assign active_zone_o = r_zone;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign abort_o       = r_abort;

endmodule
